// File: rtl/food_placer_if.sv
// Signal bundle between food_placer and its neighbours: random source,
// body tracker (occupancy map) and the display/collision consumer.
interface food_placer_if;
  logic        eat;
  logic [2:0]  rnd_y;
  logic [7:0]  rnd_x;
  logic [63:0] body_map;
  logic        rnd_req;
  logic [2:0]  food_y;
  logic [7:0]  food_x;
  logic        food_valid;
  logic        busy;
  logic        board_full;

  modport slave (
    input  eat, rnd_y, rnd_x, body_map,
    output rnd_req, food_y, food_x, food_valid, busy, board_full
  );

  modport master (
    output eat, rnd_y, rnd_x, body_map,
    input  rnd_req, food_y, food_x, food_valid, busy, board_full
  );
endinterface

// File: rtl/food_placer.sv
// Food placement controller: bounded random draws against the snake body,
// then a deterministic row-major scan, then a sticky board-full state.
//
// state | meaning
// IDLE  | food committed (or reset default); waiting for eat
// DRAW  | consume one random candidate (rnd_req high)
// CHECK | test latched candidate against body_map
// SCAN  | test cell scan_idx, one per cycle
// FULL  | no free cell; terminal until reset
module food_placer #(
  parameter int MAX_TRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  food_placer_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, DRAW, CHECK, SCAN, FULL} state_t;

  localparam logic [5:0] LAST_TRY = 6'(MAX_TRIES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cand_y_q, cand_y_d;
  logic [7:0]  cand_x_q, cand_x_d;
  logic [5:0]  try_cnt_q, try_cnt_d;
  logic [5:0]  scan_idx_q, scan_idx_d;
  logic [2:0]  food_y_q, food_y_d;
  logic [7:0]  food_x_q, food_x_d;
  logic        food_valid_q, food_valid_d;
  logic        busy_q, busy_d;
  logic        board_full_q, board_full_d;

  logic [7:0]  cand_row;
  logic        cand_onehot;
  logic        cand_hit;

  // With a one-hot column, the AND against the row isolates the single cell.
  assign cand_row    = bus.body_map[{cand_y_q, 3'b000} +: 8];
  assign cand_onehot = (cand_x_q != 8'd0) && ((cand_x_q & (cand_x_q - 8'd1)) == 8'd0);
  assign cand_hit    = cand_onehot && ((cand_row & cand_x_q) == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cand_y_q     <= 3'd0;
      cand_x_q     <= 8'd0;
      try_cnt_q    <= 6'd0;
      scan_idx_q   <= 6'd0;
      food_y_q     <= 3'b011;
      food_x_q     <= 8'b0100_0000;
      food_valid_q <= 1'b1;
      busy_q       <= 1'b0;
      board_full_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_y_q     <= cand_y_d;
      cand_x_q     <= cand_x_d;
      try_cnt_q    <= try_cnt_d;
      scan_idx_q   <= scan_idx_d;
      food_y_q     <= food_y_d;
      food_x_q     <= food_x_d;
      food_valid_q <= food_valid_d;
      busy_q       <= busy_d;
      board_full_q <= board_full_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_y_d     = cand_y_q;
    cand_x_d     = cand_x_q;
    try_cnt_d    = try_cnt_q;
    scan_idx_d   = scan_idx_q;
    food_y_d     = food_y_q;
    food_x_d     = food_x_q;
    food_valid_d = food_valid_q;
    busy_d       = busy_q;
    board_full_d = board_full_q;

    case (state_q)
      IDLE: begin
        if (bus.eat) begin
          food_valid_d = 1'b0;
          busy_d       = 1'b1;
          try_cnt_d    = 6'd0;
          state_d      = DRAW;
        end
      end
      DRAW: begin
        cand_y_d = bus.rnd_y;
        cand_x_d = bus.rnd_x;
        state_d  = CHECK;
      end
      CHECK: begin
        if (cand_hit) begin
          food_y_d     = cand_y_q;
          food_x_d     = cand_x_q;
          food_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (try_cnt_q == LAST_TRY) begin
          scan_idx_d = 6'd0;
          state_d    = SCAN;
        end else begin
          try_cnt_d = try_cnt_q + 6'd1;
          state_d   = DRAW;
        end
      end
      SCAN: begin
        if (!bus.body_map[scan_idx_q]) begin
          food_y_d     = scan_idx_q[5:3];
          food_x_d     = 8'b1 << scan_idx_q[2:0];
          food_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (scan_idx_q == 6'd63) begin
          board_full_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = FULL;
        end else begin
          scan_idx_d = scan_idx_q + 6'd1;
        end
      end
      FULL:    state_d = FULL;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rnd_req    = (state_q == DRAW);
  assign bus.food_y     = food_y_q;
  assign bus.food_x     = food_x_q;
  assign bus.food_valid = food_valid_q;
  assign bus.busy       = busy_q;
  assign bus.board_full = board_full_q;

endmodule
